id_ex_ctrl_pipe: RTL and testbench
==================================

// Module: id_ex_ctrl_pipe
// PURPOSE
// Parametrised successor to the combinational ID-stage controller: decodes OpCode/Func and registers
// control into the ID/EX pipeline register with a valid/ready handshake, stall and flush. Adds
// multi-cycle MUL sequencing (FSM + latency counter), illegal-op flagging and a wrapping issue counter.
// Sits between the ID stage and the EX-stage ALU.
// PARAMETERS
// OPW     6   opcode field width
// FUNCW   6   function field width
// ALUOPW  3   ALU operation code width (>=3)
// MUL_LAT 4   MUL occupancy in EX, cycles (>=1)
// CNTW    16  issue counter width
// PORTS
// clk          in   1       clock, rising edge
// rst_n        in   1       async reset, active low
// ID_Valid     in   1       ID holds an instruction
// ID_OpCode    in   OPW     opcode
// ID_Func      in   FUNCW   R-type function field
// ID_Ready     out  1       controller accepts this cycle
// EX_Stall     in   1       EX cannot advance; hold ID/EX register
// Flush        in   1       synchronous squash of ID/EX contents
// EX_Valid     out  1       ID/EX register holds a live instruction
// EX_ALUsrc    out  1       1 = immediate operand
// EX_ALUop     out  ALUOPW  ALU operation
// EX_Illegal   out  1       live instruction had undecodable op/func
// EX_Busy      out  1       multi-cycle MUL occupying EX
// EX_IssueCnt  out  CNTW    accepted-instruction count
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs except ID_Ready = 0; FSM=IDLE; latency counter=0.
// - Decode (comb): op 000011 ADDI->000/src1; 001111 ANDI->111/src1; 001101 ORI->011/src1;
//   op 000000 R-type src0: func 000011 ADD->000, 000010 SLL->001, 000111 AND->111, 000101 OR->011,
//   011000 MUL->010; any other op/func -> op 000, src 0, illegal 1.
// - ID_Ready = (FSM==IDLE) & !EX_Stall & !Flush (comb). Accept = ID_Valid & ID_Ready.
// - Edge priority: Flush > EX_Stall > accept > bubble.
//   Flush: EX_Valid/ALUsrc/ALUop/Illegal/Busy <= 0, FSM<=IDLE, counter<=0; overrides stall/MUL.
//   EX_Stall (no Flush): ID/EX register held; MUL counter still decrements.
//   Accept: register decoded fields, EX_Valid<=1, EX_IssueCnt<=+1 (mod 2^CNTW; not cleared by Flush).
//   Bubble (IDLE, no stall, no accept): EX_Valid/ALUsrc/ALUop/Illegal <= 0.
// - Latency: one cycle, ID fields at edge N visible on EX_* after edge N.
// - FSM IDLE/MULT. Accepting MUL with MUL_LAT>1: FSM<=MULT, EX_Busy<=1, counter<=MUL_LAT-1.
//   In MULT each edge counter-=1; edge where counter==1: counter<=0, EX_Busy<=0, FSM<=IDLE.
//   EX register held throughout MULT. ID_Ready low for exactly MUL_LAT-1 cycles after MUL issue.
//   MUL_LAT==1: MUL behaves as single-cycle op; MULT never entered, EX_Busy never set.
// - Illegal instructions are accepted normally (EX_Valid=1, EX_Illegal=1); they never enter MULT.
// - Counter width $clog2(MUL_LAT+1); no other state.
// - Reset mid-MULT: immediate return to IDLE, outputs to reset values.
// TESTING
// - Reset: rst_n=0 mid-MUL -> all EX_* 0, EX_IssueCnt 0, ID_Ready 1 with EX_Stall=0.
// - Back-to-back ADDI, AND(R), SLL(R), ORI -> EX_ALUop 000/111/001/011, ALUsrc 1/0/0/1, one per cycle.
// - MUL, MUL_LAT=4 -> EX_ALUop 010, EX_Busy high 3 cycles, ID_Ready low 3 cycles, next op after.
// - EX_Stall 2 cycles holding ADD -> EX_* unchanged, ID_Ready 0, EX_IssueCnt not incremented.
// - Flush with ID_Valid=1 during MULT -> next cycle EX_Valid 0, EX_Busy 0, FSM IDLE, no accept.
// - op 111111 and R func 111111 -> EX_Illegal 1, ALUop 000; CNTW=4, 17 accepts -> EX_IssueCnt 1.

Source files
------------

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: ID-stage decoder feeding a registered ID/EX control stage.
// Decodes OpCode/Func, accepts instructions over a valid/ready handshake, and
// supports stall, flush, multi-cycle MUL occupancy and an issue counter.
// Illegal encodings are still accepted, with EX_Illegal set.
module id_ex_ctrl_pipe #(
  parameter int OPW     = 6,
  parameter int FUNCW   = 6,
  parameter int ALUOPW  = 3,
  parameter int MUL_LAT = 4,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_Valid,
  input  logic [OPW-1:0]    ID_OpCode,
  input  logic [FUNCW-1:0]  ID_Func,
  output logic              ID_Ready,
  input  logic              EX_Stall,
  input  logic              Flush,
  output logic              EX_Valid,
  output logic              EX_ALUsrc,
  output logic [ALUOPW-1:0] EX_ALUop,
  output logic              EX_Illegal,
  output logic              EX_Busy,
  output logic [CNTW-1:0]   EX_IssueCnt
);

  localparam int LCW = $clog2(MUL_LAT + 1);

  localparam logic [OPW-1:0]    OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0]    OP_ADDI  = OPW'(6'b000011);
  localparam logic [OPW-1:0]    OP_ANDI  = OPW'(6'b001111);
  localparam logic [OPW-1:0]    OP_ORI   = OPW'(6'b001101);

  localparam logic [FUNCW-1:0]  FN_ADD   = FUNCW'(6'b000011);
  localparam logic [FUNCW-1:0]  FN_SLL   = FUNCW'(6'b000010);
  localparam logic [FUNCW-1:0]  FN_AND   = FUNCW'(6'b000111);
  localparam logic [FUNCW-1:0]  FN_OR    = FUNCW'(6'b000101);
  localparam logic [FUNCW-1:0]  FN_MUL   = FUNCW'(6'b011000);

  localparam logic [ALUOPW-1:0] ALU_ADD  = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SLL  = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_MUL  = ALUOPW'(3'b010);
  localparam logic [ALUOPW-1:0] ALU_OR   = ALUOPW'(3'b011);
  localparam logic [ALUOPW-1:0] ALU_AND  = ALUOPW'(3'b111);

  localparam logic [LCW-1:0]    LAT_ZERO = LCW'(0);
  localparam logic [LCW-1:0]    LAT_ONE  = LCW'(1);
  localparam logic [LCW-1:0]    LAT_INIT = LCW'(MUL_LAT - 1);

  // A single-cycle MUL never needs the MULT state.
  localparam logic              MUL_MULTI = (MUL_LAT > 1) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_t;

  typedef struct packed {
    logic              illegal;
    logic              src;
    logic [ALUOPW-1:0] aluop;
    logic              is_mul;
  } dec_t;

  // Pure instruction decode; anything unrecognised becomes an illegal ADD-coded op.
  function automatic dec_t decode(input logic [OPW-1:0] op, input logic [FUNCW-1:0] fn);
    dec_t d;
    d.illegal = 1'b1;
    d.src     = 1'b0;
    d.aluop   = ALU_ADD;
    d.is_mul  = 1'b0;
    case (op)
      OP_ADDI: begin d.illegal = 1'b0; d.src = 1'b1; d.aluop = ALU_ADD; end
      OP_ANDI: begin d.illegal = 1'b0; d.src = 1'b1; d.aluop = ALU_AND; end
      OP_ORI:  begin d.illegal = 1'b0; d.src = 1'b1; d.aluop = ALU_OR;  end
      OP_RTYPE: begin
        case (fn)
          FN_ADD:  begin d.illegal = 1'b0; d.aluop = ALU_ADD; end
          FN_SLL:  begin d.illegal = 1'b0; d.aluop = ALU_SLL; end
          FN_AND:  begin d.illegal = 1'b0; d.aluop = ALU_AND; end
          FN_OR:   begin d.illegal = 1'b0; d.aluop = ALU_OR;  end
          FN_MUL:  begin d.illegal = 1'b0; d.aluop = ALU_MUL; d.is_mul = 1'b1; end
          default: begin d.illegal = 1'b1; d.aluop = ALU_ADD; end
        endcase
      end
      default: begin d.illegal = 1'b1; d.aluop = ALU_ADD; end
    endcase
    return d;
  endfunction

  state_t         state_r;
  state_t         state_nx_s;
  logic [LCW-1:0] lat_cnt_r;
  logic [LCW-1:0] lat_nx_s;
  logic           busy_nx_s;
  dec_t           dec_s;
  logic           ready_s;
  logic           accept_s;
  logic           mul_issue_s;

  // Decode and handshake qualification for the instruction currently in ID.
  always_comb begin
    dec_s       = decode(ID_OpCode, ID_Func);
    ready_s     = (state_r == ST_IDLE) & ~EX_Stall & ~Flush;
    accept_s    = ID_Valid & ready_s;
    mul_issue_s = accept_s & dec_s.is_mul & MUL_MULTI;
  end

  assign ID_Ready = ready_s;

  // Next-state logic for MUL occupancy; the countdown ignores EX_Stall.
  always_comb begin
    state_nx_s = state_r;
    lat_nx_s   = lat_cnt_r;
    busy_nx_s  = EX_Busy;
    if (Flush) begin
      state_nx_s = ST_IDLE;
      lat_nx_s   = LAT_ZERO;
      busy_nx_s  = 1'b0;
    end else begin
      case (state_r)
        ST_MULT: begin
          if (lat_cnt_r == LAT_ONE) begin
            state_nx_s = ST_IDLE;
            lat_nx_s   = LAT_ZERO;
            busy_nx_s  = 1'b0;
          end else begin
            lat_nx_s   = lat_cnt_r - LAT_ONE;
          end
        end
        ST_IDLE: begin
          if (mul_issue_s) begin
            state_nx_s = ST_MULT;
            lat_nx_s   = LAT_INIT;
            busy_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          lat_nx_s   = LAT_ZERO;
          busy_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // MUL state, latency counter and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      lat_cnt_r <= LAT_ZERO;
      EX_Busy   <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      lat_cnt_r <= lat_nx_s;
      EX_Busy   <= busy_nx_s;
    end
  end

  // ID/EX control register: flush beats stall/MULT hold beats accept beats bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_Valid    <= 1'b0;
      EX_ALUsrc   <= 1'b0;
      EX_ALUop    <= ALU_ADD;
      EX_Illegal  <= 1'b0;
      EX_IssueCnt <= CNTW'(0);
    end else if (Flush) begin
      EX_Valid    <= 1'b0;
      EX_ALUsrc   <= 1'b0;
      EX_ALUop    <= ALU_ADD;
      EX_Illegal  <= 1'b0;
    end else if (EX_Stall || (state_r == ST_MULT)) begin
      EX_Valid    <= EX_Valid;
      EX_ALUsrc   <= EX_ALUsrc;
      EX_ALUop    <= EX_ALUop;
      EX_Illegal  <= EX_Illegal;
    end else if (accept_s) begin
      EX_Valid    <= 1'b1;
      EX_ALUsrc   <= dec_s.src;
      EX_ALUop    <= dec_s.aluop;
      EX_Illegal  <= dec_s.illegal;
      EX_IssueCnt <= EX_IssueCnt + CNTW'(1);
    end else begin
      EX_Valid    <= 1'b0;
      EX_ALUsrc   <= 1'b0;
      EX_ALUop    <= ALU_ADD;
      EX_Illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Scoreboard bench for id_ex_ctrl_pipe: the driver pushes the expected EX_* word
// for every clock edge it drives, and a monitor pops and compares after the edge.
module tb_id_ex_ctrl_pipe;

  localparam int MUL_LAT = 4;
  localparam int CNTW    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ID_Valid;
  logic [5:0] ID_OpCode;
  logic [5:0] ID_Func;
  logic       ID_Ready;
  logic       EX_Stall;
  logic       Flush;
  logic       EX_Valid;
  logic       EX_ALUsrc;
  logic [2:0] EX_ALUop;
  logic       EX_Illegal;
  logic       EX_Busy;
  logic [3:0] EX_IssueCnt;

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(
    .OPW(6), .FUNCW(6), .ALUOPW(3), .MUL_LAT(MUL_LAT), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid), .ID_OpCode(ID_OpCode),
    .ID_Func(ID_Func), .ID_Ready(ID_Ready), .EX_Stall(EX_Stall), .Flush(Flush),
    .EX_Valid(EX_Valid), .EX_ALUsrc(EX_ALUsrc), .EX_ALUop(EX_ALUop),
    .EX_Illegal(EX_Illegal), .EX_Busy(EX_Busy), .EX_IssueCnt(EX_IssueCnt)
  );

  int total = 0;
  int bad   = 0;

  // expected word: {valid, src, aluop[2:0], illegal, busy, issue_cnt[3:0]}
  logic [10:0] exp_q[$];

  // reference model state
  int         m_busy;   // remaining MUL occupancy cycles
  logic       m_valid;
  logic       m_src;
  logic [2:0] m_op;
  logic       m_ill;
  int         m_cnt;

  // returns {is_mul, illegal, src, aluop[2:0]} straight from the decode table
  function automatic logic [5:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000011) return {1'b0, 1'b0, 1'b1, 3'b000};
    if (op == 6'b001111) return {1'b0, 1'b0, 1'b1, 3'b111};
    if (op == 6'b001101) return {1'b0, 1'b0, 1'b1, 3'b011};
    if (op == 6'b000000) begin
      if (fn == 6'b000011) return {1'b0, 1'b0, 1'b0, 3'b000};
      if (fn == 6'b000010) return {1'b0, 1'b0, 1'b0, 3'b001};
      if (fn == 6'b000111) return {1'b0, 1'b0, 1'b0, 3'b111};
      if (fn == 6'b000101) return {1'b0, 1'b0, 1'b0, 3'b011};
      if (fn == 6'b011000) return {1'b1, 1'b0, 1'b0, 3'b010};
    end
    return {1'b0, 1'b1, 1'b0, 3'b000};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_valid = 1'b0; m_src = 1'b0; m_op = 3'b000; m_ill = 1'b0; m_cnt = 0;
  endtask

  // drive one cycle of inputs, check ready, advance the model, push the expectation
  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic st, input logic fl);
    logic       rdy;
    logic [5:0] d;
    @(negedge clk);
    ID_Valid = v; ID_OpCode = op; ID_Func = fn; EX_Stall = st; Flush = fl;
    #1;
    rdy = (m_busy == 0) && !st && !fl;
    check("id_ready", 32'(ID_Ready), 32'(rdy));
    d = ref_decode(op, fn);
    if (fl) begin
      m_valid = 1'b0; m_src = 1'b0; m_op = 3'b000; m_ill = 1'b0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end else if (st) begin
      m_busy = 0;
    end else if (v) begin
      m_valid = 1'b1; m_src = d[3]; m_op = d[2:0]; m_ill = d[4];
      m_cnt = (m_cnt + 1) % (1 << CNTW);
      if (d[5] && (MUL_LAT > 1)) m_busy = MUL_LAT - 1;
    end else begin
      m_valid = 1'b0; m_src = 1'b0; m_op = 3'b000; m_ill = 1'b0;
    end
    exp_q.push_back({m_valid, m_src, m_op, m_ill, (m_busy > 0), 4'(m_cnt)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(EX_Valid),    32'd0);
    check({tag, "_src"},     32'(EX_ALUsrc),   32'd0);
    check({tag, "_aluop"},   32'(EX_ALUop),    32'd0);
    check({tag, "_illegal"}, 32'(EX_Illegal),  32'd0);
    check({tag, "_busy"},    32'(EX_Busy),     32'd0);
    check({tag, "_cnt"},     32'(EX_IssueCnt), 32'd0);
    check({tag, "_ready"},   32'(ID_Ready),    32'd1);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; ID_Valid = 1'b0; EX_Stall = 1'b0; Flush = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: compare every expected word one step after the edge it belongs to
  initial begin
    logic [10:0] e;
    logic [10:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {EX_Valid, EX_ALUsrc, EX_ALUop, EX_Illegal, EX_Busy, EX_IssueCnt};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL ex_regs got=%b exp=%b (v,src,op,ill,busy,cnt) t=%0t", got, e, $time);
        end
      end
    end
  end

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_ANDI = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] F_ADD   = 6'b000011;
  localparam logic [5:0] F_SLL   = 6'b000010;
  localparam logic [5:0] F_AND   = 6'b000111;
  localparam logic [5:0] F_OR    = 6'b000101;
  localparam logic [5:0] F_MUL   = 6'b011000;

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    rst_n = 1'b0; ID_Valid = 1'b0; ID_OpCode = 6'd0; ID_Func = 6'd0;
    EX_Stall = 1'b0; Flush = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back ADDI, AND, SLL, ORI then a bubble
    drive(1'b1, OP_ADDI, 6'd0,  1'b0, 1'b0);
    drive(1'b1, OP_R,    F_AND, 1'b0, 1'b0);
    drive(1'b1, OP_R,    F_SLL, 1'b0, 1'b0);
    drive(1'b1, OP_ORI,  6'd0,  1'b0, 1'b0);
    drive(1'b0, OP_ANDI, 6'd0,  1'b0, 1'b0);

    // MUL then an ADD waiting through the occupancy window
    drive(1'b1, OP_R, F_MUL, 1'b0, 1'b0);
    for (int i = 0; i < MUL_LAT; i++) drive(1'b1, OP_R, F_ADD, 1'b0, 1'b0);

    // ADD held by two stall cycles while ID offers ADDI
    drive(1'b1, OP_R,    F_ADD, 1'b0, 1'b0);
    drive(1'b1, OP_ADDI, 6'd0,  1'b1, 1'b0);
    drive(1'b1, OP_ADDI, 6'd0,  1'b1, 1'b0);
    drive(1'b1, OP_ADDI, 6'd0,  1'b0, 1'b0);

    // flush in MULT with ID_Valid high
    drive(1'b1, OP_R, F_MUL, 1'b0, 1'b0);
    drive(1'b1, OP_R, F_OR,  1'b0, 1'b0);
    drive(1'b1, OP_R, F_OR,  1'b0, 1'b1);
    drive(1'b0, OP_R, F_OR,  1'b0, 1'b0);

    // illegal opcode and illegal R func
    drive(1'b1, 6'b111111, 6'd0,      1'b0, 1'b0);
    drive(1'b1, OP_R,      6'b111111, 1'b0, 1'b0);
    drive(1'b0, OP_R,      6'd0,      1'b0, 1'b0);

    // reset while a MUL is in flight
    drive(1'b1, OP_R, F_MUL, 1'b0, 1'b0);
    drive(1'b0, OP_R, F_ADD, 1'b0, 1'b0);
    apply_reset("mid_mul");

    // issue counter wraps: 17 accepts from zero with a 4-bit counter
    for (int i = 0; i < 17; i++) drive(1'b1, OP_R, F_ADD, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("issue_wrap", 32'(EX_IssueCnt), 32'd1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 6))
        0:       rop = OP_ADDI;
        1:       rop = OP_ANDI;
        2:       rop = OP_ORI;
        3, 4, 5: rop = OP_R;
        default: rop = 6'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0:       rfn = F_ADD;
        1:       rfn = F_SLL;
        2:       rfn = F_AND;
        3:       rfn = F_OR;
        4, 5:    rfn = F_MUL;
        default: rfn = 6'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), rop, rfn,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    for (int i = 0; i < 3; i++) drive(1'b0, OP_R, 6'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
